// File: rtl/seq_det_prog_if.sv
// Serial-stream and configuration bundle for the programmable pattern detector.
// The master side drives the bit stream and configuration; the slave side returns detection status.
interface seq_det_prog_if #(
  parameter int unsigned PAT_W = 4,
  parameter int unsigned CNT_W = 8
);

  logic             in_valid;
  logic             in;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pat;
  logic             cfg_ovl;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             armed;

  modport master (
    output in_valid, in, cfg_load, cfg_pat, cfg_ovl,
    input  match, match_cnt, armed
  );

  modport slave (
    input  in_valid, in, cfg_load, cfg_pat, cfg_ovl,
    output match, match_cnt, armed
  );

endinterface

// File: rtl/seq_det_prog.sv
// Programmable serial pattern detector: runtime pattern/overlap configuration,
// qualified input stream, registered match pulse and saturating match counter.
module seq_det_prog #(
  parameter int unsigned      PAT_W   = 4,
  parameter int unsigned      CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(4'b1011),
  parameter logic             DEF_OVL = 1'b1
) (
  input logic          clk,
  input logic          rst,
  seq_det_prog_if.slave bus
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_FILLING = 2'd1,
    ST_ARMED   = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nx;
  logic [PAT_W-1:0]  pat_r;
  logic              ovl_r;
  logic [PAT_W-1:0]  hist_r;
  logic [PAT_W-1:0]  hist_nx;
  logic [FILL_W-1:0] fill_r;
  logic [FILL_W-1:0] fill_nx;
  logic              match_r;
  logic              match_nx;
  logic              armed_r;
  logic              armed_nx;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nx;

  logic              consume_c;
  logic [PAT_W-1:0]  shifted_c;
  logic              hit_c;

  // A configuration load takes priority over any bit presented in the same cycle.
  assign consume_c = bus.in_valid & ~bus.cfg_load;
  assign shifted_c = {hist_r[PAT_W-2:0], bus.in};
  assign hit_c     = consume_c && (fill_r >= FILL_LAST) && (shifted_c == pat_r);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nx;
    end
  end

  // History/fill update and fill-derived state.
  always_comb begin
    hist_nx  = hist_r;
    fill_nx  = fill_r;
    state_nx = state_r;
    if (bus.cfg_load || (hit_c && !ovl_r)) begin
      hist_nx = '0;
      fill_nx = '0;
    end else if (consume_c) begin
      hist_nx = shifted_c;
      if (state_r != ST_ARMED) begin
        fill_nx = fill_r + FILL_W'(1);
      end
    end
    if (fill_nx == '0) begin
      state_nx = ST_EMPTY;
    end else if (fill_nx == FILL_FULL) begin
      state_nx = ST_ARMED;
    end else begin
      state_nx = ST_FILLING;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    match_nx = hit_c;
    armed_nx = (state_nx == ST_ARMED);
    cnt_nx   = cnt_r;
    if (bus.cfg_load) begin
      cnt_nx = '0;
    end else if (hit_c && (cnt_r != CNT_MAX)) begin
      cnt_nx = cnt_r + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_r   <= DEF_PAT;
      ovl_r   <= DEF_OVL;
      hist_r  <= '0;
      fill_r  <= '0;
      match_r <= 1'b0;
      armed_r <= 1'b0;
      cnt_r   <= '0;
    end else begin
      if (bus.cfg_load) begin
        pat_r <= bus.cfg_pat;
        ovl_r <= bus.cfg_ovl;
      end
      hist_r  <= hist_nx;
      fill_r  <= fill_nx;
      match_r <= match_nx;
      armed_r <= armed_nx;
      cnt_r   <= cnt_nx;
    end
  end

  assign bus.match     = match_r;
  assign bus.match_cnt = cnt_r;
  assign bus.armed     = armed_r;

endmodule

// File: tb/tb_seq_det_prog.sv
// Bench for seq_det_prog: directed scenarios plus random traffic on a 4-bit and
// a 2-bit instance, each checked against a queue-based reference model.
module tb_seq_det_prog;

  localparam int unsigned PW_A = 4;
  localparam int unsigned CW_A = 8;
  localparam int unsigned PW_B = 2;
  localparam int unsigned CW_B = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_det_prog_if #(.PAT_W(PW_A), .CNT_W(CW_A)) bus_a ();
  seq_det_prog_if #(.PAT_W(PW_B), .CNT_W(CW_B)) bus_b ();

  seq_det_prog #(.PAT_W(PW_A), .CNT_W(CW_A), .DEF_PAT(4'b1011), .DEF_OVL(1'b1)) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  seq_det_prog #(.PAT_W(PW_B), .CNT_W(CW_B), .DEF_PAT(2'b11), .DEF_OVL(1'b1)) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the consumed bits since the last clear, kept as a queue.
  bit          q0[$];
  bit          q1[$];
  int unsigned m_pat[2];
  int unsigned m_ovl[2];
  int unsigned m_cnt[2];
  bit          m_match[2];
  bit          m_armed[2];
  int unsigned pw[2]      = '{4, 2};
  int unsigned cmax[2]    = '{255, 3};
  int unsigned def_pat[2] = '{11, 3};

  task automatic model_edge(input int k, input bit r, input bit v, input bit b,
                            input bit ld, input int unsigned cp, input bit co);
    bit q[$];
    int unsigned val;
    if (k == 0) q = q0; else q = q1;
    m_match[k] = 1'b0;
    if (r) begin
      q.delete();
      m_pat[k] = def_pat[k];
      m_ovl[k] = 1;
      m_cnt[k] = 0;
    end else if (ld) begin
      q.delete();
      m_pat[k] = cp;
      m_ovl[k] = co;
      m_cnt[k] = 0;
    end else if (v) begin
      q.push_back(b);
      while (q.size() > pw[k]) void'(q.pop_front());
      if (q.size() == pw[k]) begin
        val = 0;
        foreach (q[i]) val = val * 2 + q[i];
        if (val == m_pat[k]) begin
          m_match[k] = 1'b1;
          if (m_cnt[k] < cmax[k]) m_cnt[k]++;
          if (m_ovl[k] == 0) q.delete();
        end
      end
    end
    m_armed[k] = (q.size() == pw[k]);
    if (k == 0) q0 = q; else q1 = q;
  endtask

  function automatic logic [9:0] obs(input int k);
    if (k == 0) return {bus_a.match, bus_a.match_cnt, bus_a.armed};
    return {6'd0, bus_b.match, bus_b.match_cnt, bus_b.armed};
  endfunction

  function automatic logic [9:0] expv(input int k);
    if (k == 0) return {m_match[0], 8'(m_cnt[0]), m_armed[0]};
    return {6'd0, m_match[1], 2'(m_cnt[1]), m_armed[1]};
  endfunction

  // One clock: drive instance k (the other idles), let the edge happen, update the model.
  task automatic step(input int k, input bit r, input bit v, input bit b,
                      input bit ld, input int unsigned cp, input bit co);
    rst            = r;
    bus_a.in_valid = (k == 0) && v;
    bus_a.in       = b;
    bus_a.cfg_load = (k == 0) && ld;
    bus_a.cfg_pat  = 4'(cp);
    bus_a.cfg_ovl  = co;
    bus_b.in_valid = (k == 1) && v;
    bus_b.in       = b;
    bus_b.cfg_load = (k == 1) && ld;
    bus_b.cfg_pat  = 2'(cp);
    bus_b.cfg_ovl  = co;
    @(posedge clk);
    model_edge(0, r, (k == 0) && v, b, (k == 0) && ld, cp, co);
    model_edge(1, r, (k == 1) && v, b, (k == 1) && ld, cp, co);
    #1;
  endtask

  task automatic test_reset();
    logic [6:0] s = 7'b1011011;
    int pulses = 0;
    step(0, 1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (obs(0) !== 10'd0) begin bad++; $display("FAIL reset_a_init: got %h want %h", obs(0), 10'd0); end
    total++;
    if (obs(1) !== 10'd0) begin bad++; $display("FAIL reset_b_init: got %h want %h", obs(1), 10'd0); end
    step(0, 0, 0, 0, 1, 6, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, (i != 1), 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 1, 0, 0, 0);
      total++;
      if (obs(0) !== 10'd0) begin bad++; $display("FAIL reset_mid: cycle %0d got %h want %h", i, obs(0), 10'd0); end
    end
    for (int i = 6; i >= 0; i--) begin
      step(0, 0, 1, s[i], 0, 0, 0);
      total++;
      if (obs(0) !== expv(0)) begin bad++; $display("FAIL reset_restore: got %h want %h", obs(0), expv(0)); end
      if (bus_a.match === 1'b1) pulses++;
    end
    total++;
    if (pulses !== 2) begin bad++; $display("FAIL reset_default_pat: pulses %0d want 2", pulses); end
  endtask

  task automatic run_stream(input string name, input bit ovl, input logic [6:0] want_mask,
                            input int unsigned want_cnt);
    logic [6:0] s = 7'b1011011;
    logic [6:0] mask = '0;
    step(0, 0, 0, 0, 1, 11, ovl);
    for (int i = 6; i >= 0; i--) begin
      step(0, 0, 1, s[i], 0, 0, 0);
      total++;
      if (obs(0) !== expv(0)) begin bad++; $display("FAIL %s_bit%0d: got %h want %h", name, 7 - i, obs(0), expv(0)); end
      mask[6-i] = bus_a.match;
    end
    total++;
    if (mask !== want_mask) begin bad++; $display("FAIL %s_pulses: got %b want %b", name, mask, want_mask); end
    total++;
    if (bus_a.match_cnt !== 8'(want_cnt)) begin bad++; $display("FAIL %s_cnt: got %0d want %0d", name, bus_a.match_cnt, want_cnt); end
  endtask

  task automatic test_overlap();
    run_stream("overlap", 1'b1, 7'b1001000, 2);
  endtask

  task automatic test_non_overlap();
    run_stream("non_overlap", 1'b0, 7'b0001000, 1);
  endtask

  task automatic test_bubbles();
    logic [3:0] s = 4'b1011;
    logic [3:0] mask = '0;
    int gap_pulses = 0;
    step(0, 0, 0, 0, 1, 11, 1);
    for (int i = 3; i >= 0; i--) begin
      step(0, 0, 1, s[i], 0, 0, 0);
      total++;
      if (obs(0) !== expv(0)) begin bad++; $display("FAIL bubbles_bit: got %h want %h", obs(0), expv(0)); end
      mask[3-i] = bus_a.match;
      for (int g = 0; g < 3; g++) begin
        step(0, 0, 0, $urandom_range(0, 1), 0, $urandom_range(0, 15), 0);
        total++;
        if (obs(0) !== expv(0)) begin bad++; $display("FAIL bubbles_gap: got %h want %h", obs(0), expv(0)); end
        if (bus_a.match === 1'b1) gap_pulses++;
      end
    end
    total++;
    if (mask !== 4'b1000) begin bad++; $display("FAIL bubbles_pulses: got %b want 1000", mask); end
    total++;
    if (gap_pulses !== 0) begin bad++; $display("FAIL bubbles_gap_pulses: got %0d want 0", gap_pulses); end
  endtask

  task automatic test_cfg_collision();
    logic [3:0] s = 4'b1011;
    logic [3:0] mask = '0;
    step(0, 0, 0, 0, 1, 11, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, (i != 1), 0, 0, 0);
    step(0, 0, 1, 1, 1, 11, 1);
    total++;
    if (obs(0) !== 10'd0) begin bad++; $display("FAIL collision_clear: got %h want %h", obs(0), 10'd0); end
    for (int i = 3; i >= 0; i--) begin
      step(0, 0, 1, s[i], 0, 0, 0);
      total++;
      if (obs(0) !== expv(0)) begin bad++; $display("FAIL collision_bit: got %h want %h", obs(0), expv(0)); end
      mask[3-i] = bus_a.match;
    end
    total++;
    if (mask !== 4'b1000) begin bad++; $display("FAIL collision_pulses: got %b want 1000", mask); end
  endtask

  task automatic test_back_to_back_saturation();
    logic [5:0] mask = '0;
    step(1, 0, 0, 0, 1, 3, 1);
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 1, 1, 0, 0, 0);
      total++;
      if (obs(1) !== expv(1)) begin bad++; $display("FAIL sat_bit%0d: got %h want %h", i + 1, obs(1), expv(1)); end
      mask[i] = bus_b.match;
    end
    total++;
    if (mask !== 6'b111110) begin bad++; $display("FAIL sat_pulses: got %b want 111110", mask); end
    total++;
    if (bus_b.match_cnt !== 2'd3) begin bad++; $display("FAIL sat_cnt: got %0d want 3", bus_b.match_cnt); end
  endtask

  task automatic test_random();
    int k;
    for (int n = 0; n < 800; n++) begin
      k = $urandom_range(0, 1);
      step(k, ($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
           ($urandom_range(0, 39) == 0), $urandom_range(0, (k == 0) ? 15 : 3), $urandom_range(0, 1));
      total++;
      if (obs(0) !== expv(0)) begin bad++; $display("FAIL random_a: step %0d got %h want %h", n, obs(0), expv(0)); end
      total++;
      if (obs(1) !== expv(1)) begin bad++; $display("FAIL random_b: step %0d got %h want %h", n, obs(1), expv(1)); end
    end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in = 1'b0; bus_a.cfg_load = 1'b0; bus_a.cfg_pat = '0; bus_a.cfg_ovl = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in = 1'b0; bus_b.cfg_load = 1'b0; bus_b.cfg_pat = '0; bus_b.cfg_ovl = 1'b0;
    test_reset();
    test_overlap();
    test_non_overlap();
    test_bubbles();
    test_cfg_collision();
    test_back_to_back_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
